output_serializer: RTL and testbench
====================================

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 Parameter IN_WIDTH, default 512, width of one systolic result frame in bits.
REQ-002 Parameter OUT_WIDTH, default 64, width of one output beat in bits.
REQ-003 Parameter DEPTH, default 2, number of whole frames the block SHALL buffer.
REQ-004 clk  input  1  clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  producer offers a frame.
REQ-007 in_ready  output  1  block can accept a frame.
REQ-008 in_data  input  IN_WIDTH  frame payload.
REQ-009 out_valid  output  1  beat on out_data is valid.
REQ-010 out_ready  input  1  consumer accepts the beat.
REQ-011 out_data  output  OUT_WIDTH  current beat.
REQ-012 out_last  output  1  current beat is the final beat of its frame.
REQ-013 frame_done  output  1  one-cycle pulse per fully transmitted frame.

Function
REQ-014 BEATS SHALL equal IN_WIDTH/OUT_WIDTH; IN_WIDTH not a multiple of OUT_WIDTH, BEATS<2 or DEPTH<1 SHALL be an elaboration error.
REQ-015 A frame SHALL be accepted on any cycle with in_valid && in_ready; in_ready SHALL be !full, with no combinational path from out_ready or in_valid.
REQ-016 When full, in_ready SHALL stay 0 even on a cycle when a frame is popped; the freed slot becomes visible the next cycle.
REQ-017 Serializer FSM states: IDLE (no frame loaded) and SEND (frame in shift register).
REQ-018 IDLE -> SEND when the buffer is non-empty; the oldest frame is popped and loaded in that cycle, and out_valid rises the following cycle.
REQ-019 Latency: a frame accepted in cycle t into an empty block in IDLE SHALL produce out_valid in cycle t+2.
REQ-020 Beat k (0..BEATS-1) SHALL be in_data[k*OUT_WIDTH +: OUT_WIDTH], LSB beat first.
REQ-021 While out_valid && !out_ready, out_data, out_last and the beat index SHALL hold unchanged.
REQ-022 The beat index SHALL advance only on out_valid && out_ready; out_last SHALL be 1 exactly when the index equals BEATS-1.
REQ-023 On the last-beat handshake: with the buffer non-empty, load the next frame in the same cycle and stay in SEND with no bubble; otherwise go to IDLE with out_valid 0 next cycle.
REQ-024 frame_done SHALL pulse for one cycle, in the cycle after each last-beat handshake.
REQ-025 A simultaneous push and pop SHALL keep the occupancy unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 While rst is high: in_ready, out_valid, out_last and frame_done = 0; out_data = 0; FSM = IDLE; beat index, pointers and occupancy = 0.
REQ-027 Reset asserted mid-frame SHALL discard all buffered and partially sent frames without emitting frame_done; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 With OSER_BEAT_IDX_EN defined, an extra output out_beat_idx [$clog2(BEATS)-1:0] SHALL carry the current beat index, 0 in reset and aligned with out_data.
REQ-029 Without OSER_BEAT_IDX_EN the port SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package oser_pkg SHALL hold the default width/depth constants and the FSM state enum (OSER_IDLE, OSER_SEND).
REQ-031 Frame storage SHALL be a sub-module oser_frame_fifo (IN_WIDTH x DEPTH, push/pop/full/empty); the FSM, shift register and beat counter SHALL be in output_serializer.

Verification (IN_WIDTH=512, OUT_WIDTH=64, DEPTH=2)
REQ-032 Single frame: in_data = beat k value 64'h0..k, out_ready = 1 -> out_valid at t+2, beats 0..7 in order, out_last on beat 7, frame_done one cycle later.
REQ-033 Back-pressure: out_ready toggles 1,0,0,1 repeating -> out_data holds during stalls, 8 beats total, no beat duplicated or lost.
REQ-034 Fill: 3 frames offered back-to-back with out_ready = 0 -> 2 accepted, in_ready = 0 with 2 buffered; raising out_ready -> 16 contiguous beats with no bubble at the frame boundary, then the 3rd frame accepted.
REQ-035 Reset mid-frame: rst for 1 cycle after beat 3 -> outputs 0, no frame_done, next frame starts at beat 0.
REQ-036 Full with pop: buffer full and a last-beat handshake in the same cycle -> in_ready stays 0 that cycle and is 1 the next.
REQ-037 With OSER_BEAT_IDX_EN defined: out_beat_idx steps 0..7 in step with out_data.

Source files
------------

// File: rtl/oser_pkg.sv
// oser_pkg: shared constants and types for output_serializer.
//   OSER_IN_WIDTH / OSER_OUT_WIDTH / OSER_DEPTH : default frame width,
//   beat width and frame-buffer depth.
//   oser_state_t : serializer FSM state (OSER_IDLE, OSER_SEND).
package oser_pkg;

    localparam int unsigned OSER_IN_WIDTH  = 512;
    localparam int unsigned OSER_OUT_WIDTH = 64;
    localparam int unsigned OSER_DEPTH     = 2;

    typedef enum logic {
        OSER_IDLE = 1'b0,
        OSER_SEND = 1'b1
    } oser_state_t;

endpackage

// File: rtl/oser_frame_fifo.sv
// oser_frame_fifo: whole-frame FIFO, WIDTH bits x DEPTH entries.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one frame (ignored when full)
//   pop,  pop_data  : read-ahead oldest frame; pop removes it (ignored when empty)
//   full, empty     : occupancy flags, derived from registered state only
module oser_frame_fifo #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/output_serializer.sv
// output_serializer: buffers up to DEPTH result frames of IN_WIDTH bits and
// emits each as IN_WIDTH/OUT_WIDTH beats, LSB beat first, valid/ready on both sides.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid, in_ready, in_data : frame input handshake
//   out_valid, out_ready        : beat output handshake
//   out_data, out_last          : current beat, final-beat-of-frame flag
//   frame_done                  : one-cycle pulse after each frame's last beat
//   out_beat_idx                : current beat index (only with OSER_BEAT_IDX_EN)
// Optional feature macro: OSER_BEAT_IDX_EN.
module output_serializer
    import oser_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = OSER_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = OSER_OUT_WIDTH,
    parameter int unsigned DEPTH     = OSER_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
`ifdef OSER_BEAT_IDX_EN
    output logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] out_beat_idx,
`endif
    output logic                 frame_done
);

    localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (((IN_WIDTH % OUT_WIDTH) != 0) || (BEATS < 2) || (DEPTH < 1)) begin : g_bad_cfg
        $error("output_serializer: illegal IN_WIDTH/OUT_WIDTH/DEPTH combination");
    end

    oser_state_t         state;
    oser_state_t         state_next;
    logic                send_active;
    logic [IN_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]    beat_idx;
    logic                frame_done_q;
    logic                is_last;
    logic                beat_hs;
    logic                last_hs;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [IN_WIDTH-1:0] fifo_rd_data;

    oser_frame_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign is_last = (beat_idx == IDX_W'(BEATS - 1));
    assign beat_hs = send_active && out_ready;
    assign last_hs = beat_hs && is_last;
    assign push    = in_valid && in_ready;
    // Load from the buffer when idle, or back-to-back on the last-beat handshake.
    assign pop     = !fifo_empty && (!send_active || last_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OSER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OSER_IDLE: if (!fifo_empty)            state_next = OSER_SEND;
            OSER_SEND: if (last_hs && fifo_empty)  state_next = OSER_IDLE;
            default:                               state_next = OSER_IDLE;
        endcase
    end

    always_comb begin
        send_active = (state == OSER_SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            beat_idx     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= last_hs;
            if (pop) begin
                shreg <= fifo_rd_data;
            end else if (beat_hs) begin
                shreg <= shreg >> OUT_WIDTH;
            end
            if (pop || last_hs) begin
                beat_idx <= '0;
            end else if (beat_hs) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
        end
    end

    // Outputs are forced low for the whole time rst is held, not just after the first edge.
    assign in_ready   = !fifo_full && !rst;
    assign out_valid  = send_active && !rst;
    assign out_last   = send_active && is_last && !rst;
    assign out_data   = rst ? '0 : shreg[OUT_WIDTH-1:0];
    assign frame_done = frame_done_q && !rst;
`ifdef OSER_BEAT_IDX_EN
    assign out_beat_idx = rst ? '0 : beat_idx;
`endif

endmodule

// File: tb/tb_output_serializer.sv
module tb_output_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         out_last;
    logic         frame_done;
`ifdef OSER_BEAT_IDX_EN
    logic [2:0]   out_beat_idx;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    output_serializer #(
        .IN_WIDTH  (512),
        .OUT_WIDTH (64),
        .DEPTH     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
`ifdef OSER_BEAT_IDX_EN
        .out_beat_idx (out_beat_idx),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_frame(input logic [63:0] base);
        logic [511:0] f;
        for (int k = 0; k < 8; k++) f[k*64 +: 64] = base + 64'(k);
        return f;
    endfunction

    task automatic chk_idx(input logic [63:0] exp);
`ifdef OSER_BEAT_IDX_EN
        chk("beat_idx", 64'(out_beat_idx), exp);
`else
        if (exp > 64'd7) chk("beat_idx_range", exp, 64'd7);
`endif
    endtask

    // Offers one frame with out_ready high and checks latency, all beats and frame_done.
    task automatic send_and_check(input logic [63:0] base);
        chk("pre_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = mk_frame(base);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_t1_valid", 64'(out_valid), 64'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("sf_valid", 64'(out_valid), 64'd1);
            chk("sf_data", out_data, base + 64'(k));
            chk("sf_last", 64'(out_last), 64'(k == 7));
            chk("sf_done_early", 64'(frame_done), 64'd0);
            chk_idx(64'(k));
            tick();
        end
        chk("sf_done", 64'(frame_done), 64'd1);
        chk("sf_idle_valid", 64'(out_valid), 64'd0);
        tick();
        chk("sf_done_pulse", 64'(frame_done), 64'd0);
    endtask

    initial begin
        int unsigned ei;
        int unsigned cyc;
        logic        rdy;
        logic [3:0]  pat;
        logic [63:0] base;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        pat = 4'b1001;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk_idx(64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single frame, beat k = k
        send_and_check(64'h0);

        // Back-pressure with out_ready pattern 1,0,0,1
        in_valid = 1'b1; in_data = mk_frame(64'h100); out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        ei = 0;
        cyc = 0;
        while (ei < 8 && cyc < 100) begin
            rdy = pat[3 - (cyc % 4)];
            out_ready = rdy;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", out_data, 64'h100 + 64'(ei));
            chk("bp_last", 64'(out_last), 64'(ei == 7));
            chk_idx(64'(ei));
            if (rdy) ei++;
            cyc++;
            tick();
        end
        chk("bp_beat_count", 64'(ei), 64'd8);
        chk("bp_done", 64'(frame_done), 64'd1);
        chk("bp_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        tick();

        // Fill: one frame stalled in the shifter, then offer three more
        in_valid = 1'b1; in_data = mk_frame(64'h200);
        tick();
        in_valid = 1'b0;
        tick();
        chk("fill_p_valid", 64'(out_valid), 64'd1);
        chk("fill_f1_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_data = mk_frame(64'h300);
        tick();
        chk("fill_f2_ready", 64'(in_ready), 64'd1);
        in_data = mk_frame(64'h400);
        tick();
        chk("fill_full_ready", 64'(in_ready), 64'd0);
        in_data = mk_frame(64'h500);
        tick();
        chk("fill_full_hold", 64'(in_ready), 64'd0);
        chk("fill_hold_data", out_data, 64'h200);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 8) in_valid = 1'b0;
            base = 64'h200 + 64'h100 * 64'(i / 8);
            chk("fill_valid", 64'(out_valid), 64'd1);
            chk("fill_data", out_data, base + 64'(i % 8));
            chk("fill_last", 64'(out_last), 64'((i % 8) == 7));
            chk("fill_in_ready", 64'(in_ready), 64'((i == 8) || (i >= 16)));
            chk("fill_done", 64'(frame_done), 64'((i % 8) == 0 && i > 0));
            chk_idx(64'(i % 8));
            tick();
        end
        chk("fill_end_done", 64'(frame_done), 64'd1);
        chk("fill_end_idle", 64'(out_valid), 64'd0);
        tick();

        // Reset mid-frame with a second frame buffered
        in_valid = 1'b1; in_data = mk_frame(64'h600); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = (k == 1);
            in_data  = mk_frame(64'h700);
            chk("mr_data", out_data, 64'h600 + 64'(k));
            tick();
        end
        in_valid = 1'b0;
        chk("mr_beat4", out_data, 64'h604);
        rst = 1'b1;
        #1;
        chk("mr_rst_valid", 64'(out_valid), 64'd0);
        chk("mr_rst_ready", 64'(in_ready), 64'd0);
        chk("mr_rst_data", out_data, 64'd0);
        chk("mr_rst_last", 64'(out_last), 64'd0);
        chk("mr_rst_done", 64'(frame_done), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_post_valid", 64'(out_valid), 64'd0);
        chk("mr_post_data", out_data, 64'd0);
        chk_idx(64'd0);
        tick();
        chk("mr_first_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("mr_flush_valid", 64'(out_valid), 64'd0);
            chk("mr_flush_done", 64'(frame_done), 64'd0);
            tick();
        end
        send_and_check(64'h800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
